// File: rtl/prot_mem_wrapper_2p.sv
// Two-port (1W/1R) memory wrapper with selectable protection (none / parity / SECDED),
// configurable read pipeline, error injection, saturating error counters and first-error capture.

module flop_array_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Registered read samples the array before this cycle's write lands: read-before-write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

module prot_mem_wrapper_2p #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int PROT_MODE  = 2,
    parameter int RD_PIPE    = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  inj_sb,
    input  logic                  inj_db,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  sb_err,
    output logic                  db_err,
    input  logic                  clr_err,
    output logic [CNT_WIDTH-1:0]  sb_cnt,
    output logic [CNT_WIDTH-1:0]  db_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_addr_vld
);
    function automatic int calc_r(input int dw);
        int r;
        r = 1;
        for (int i = 0; i < 12; i++) begin
            if ((1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    localparam int R     = calc_r(DATA_WIDTH);
    localparam int N_HAM = DATA_WIDTH + R;
    localparam int CHK_W = (PROT_MODE == 0) ? 0 : ((PROT_MODE == 1) ? 1 : R + 1);
    localparam int CW_W  = DATA_WIDTH + CHK_W;

    // Hamming positions 1..N_HAM; powers of two hold check bits, the rest hold data bits in order.
    function automatic logic [R-1:0] ham_bits(input logic [DATA_WIDTH-1:0] d);
        logic [R-1:0] h;
        int k;
        h = '0;
        k = 0;
        for (int p = 1; p <= N_HAM; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int j = 0; j < R; j++) begin
                    if (p[j]) h[j] = h[j] ^ d[k];
                end
                k++;
            end
        end
        return h;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ham_correct(input logic [DATA_WIDTH-1:0] d,
                                                          input logic [R-1:0]          syn);
        logic [DATA_WIDTH-1:0] c;
        int k;
        c = d;
        k = 0;
        for (int p = 1; p <= N_HAM; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (p == int'(syn)) c[k] = ~c[k];
                k++;
            end
        end
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                      input logic                 inc);
        if (inc && (c != '1)) return c + 1'b1;
        return c;
    endfunction

    logic [1:0]            inj_mask;
    logic [CW_W-1:0]       wr_cw;
    logic [CW_W-1:0]       cw_p0;
    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] raddr_p0;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  dec_sb;
    logic                  dec_db;

    always_comb begin
        inj_mask = 2'b00;
        if (wr && inj_db)      inj_mask = 2'b11;
        else if (wr && inj_sb) inj_mask = 2'b01;
    end

    if (PROT_MODE == 0) begin : g_none
        assign wr_cw    = wdata;
        assign dec_data = cw_p0;
        assign dec_sb   = 1'b0;
        assign dec_db   = 1'b0;
    end else if (PROT_MODE == 1) begin : g_parity
        assign wr_cw    = {^wdata, wdata} ^ CW_W'(inj_mask);
        assign dec_data = cw_p0[DATA_WIDTH-1:0];
        assign dec_sb   = 1'b0;
        assign dec_db   = ^cw_p0;
    end else begin : g_secded
        logic [R-1:0] ham_w;
        logic [R-1:0] syn;
        logic         ovr;

        assign ham_w = ham_bits(wdata);
        assign wr_cw = {^{ham_w, wdata}, ham_w, wdata} ^ CW_W'(inj_mask);

        // Odd overall parity means one flipped bit; a syndrome past the last position is uncorrectable.
        always_comb begin
            syn      = ham_bits(cw_p0[DATA_WIDTH-1:0]) ^ cw_p0[DATA_WIDTH +: R];
            ovr      = ^cw_p0;
            dec_data = cw_p0[DATA_WIDTH-1:0];
            dec_sb   = 1'b0;
            dec_db   = 1'b0;
            if (ovr) begin
                if (int'(syn) <= N_HAM) begin
                    dec_sb   = 1'b1;
                    dec_data = ham_correct(cw_p0[DATA_WIDTH-1:0], syn);
                end else begin
                    dec_db = 1'b1;
                end
            end else if (syn != '0) begin
                dec_db = 1'b1;
            end
        end
    end

    flop_array_2p #(
        .WIDTH (CW_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (wr),
        .waddr (waddr),
        .wdata (wr_cw),
        .re    (rd),
        .raddr (raddr),
        .rdata (cw_p0)
    );

    // Stage p0: array output, read strobe and address aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= rd;
    end

    always_ff @(posedge clk) begin
        if (rd) raddr_p0 <= raddr;
    end

    for (genvar k = 1; k <= RD_PIPE; k++) begin : g_stage
        logic                  vld_in;
        logic                  sb_in;
        logic                  db_in;
        logic [DATA_WIDTH-1:0] data_in;
        logic [ADDR_WIDTH-1:0] addr_in;
        logic                  vld_p;
        logic                  sb_p;
        logic                  db_p;
        logic [DATA_WIDTH-1:0] data_p;
        logic [ADDR_WIDTH-1:0] addr_p;

        if (k == 1) begin : g_first
            assign vld_in  = vld_p0;
            assign sb_in   = dec_sb;
            assign db_in   = dec_db;
            assign data_in = dec_data;
            assign addr_in = raddr_p0;
        end else begin : g_next
            assign vld_in  = g_stage[k-1].vld_p;
            assign sb_in   = g_stage[k-1].sb_p;
            assign db_in   = g_stage[k-1].db_p;
            assign data_in = g_stage[k-1].data_p;
            assign addr_in = g_stage[k-1].addr_p;
        end

        // Stage p<k>: flags are qualified by valid so they read 0 between reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= 1'b0;
                sb_p  <= 1'b0;
                db_p  <= 1'b0;
            end else begin
                vld_p <= vld_in;
                sb_p  <= vld_in & sb_in;
                db_p  <= vld_in & db_in;
            end
        end

        if (k == RD_PIPE) begin : g_last
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         data_p <= '0;
                else if (vld_in) data_p <= data_in;
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (vld_in) data_p <= data_in;
            end
        end

        always_ff @(posedge clk) begin
            if (vld_in) addr_p <= addr_in;
        end
    end

    assign rdata  = g_stage[RD_PIPE].data_p;
    assign rvalid = g_stage[RD_PIPE].vld_p;
    assign sb_err = g_stage[RD_PIPE].sb_p;
    assign db_err = g_stage[RD_PIPE].db_p;

    // A clear coinciding with a new error restarts the statistics from that error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_cnt       <= '0;
            db_cnt       <= '0;
            err_addr     <= '0;
            err_addr_vld <= 1'b0;
        end else begin
            if (clr_err) begin
                sb_cnt <= CNT_WIDTH'(sb_err);
                db_cnt <= CNT_WIDTH'(db_err);
            end else begin
                sb_cnt <= sat_inc(sb_cnt, sb_err);
                db_cnt <= sat_inc(db_cnt, db_err);
            end
            if (clr_err || !err_addr_vld) begin
                if (sb_err || db_err) begin
                    err_addr     <= g_stage[RD_PIPE].addr_p;
                    err_addr_vld <= 1'b1;
                end else if (clr_err) begin
                    err_addr     <= '0;
                    err_addr_vld <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_prot_mem_wrapper_2p.sv
// Scoreboard bench: four wrapper variants share one stimulus stream and are checked against
// a word-level memory model that tracks data and injected faults per address.

module tb_prot_mem_wrapper_2p;
    typedef struct {
        logic [31:0] d;
        bit          sb;
        bit          db;
        int          cyc;
        logic [3:0]  addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, inj_sb = 1'b0, inj_db = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [3:0]  waddr = '0, raddr = '0;
    logic [31:0] wdata = '0;
    logic [8:0]  waddr9, raddr9;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    assign waddr9 = {5'd0, waddr};
    assign raddr9 = {5'd0, raddr};

    logic [31:0] rdata_a, rdata_b, rdata_c, rdata_d;
    logic        rvalid_a, rvalid_b, rvalid_c, rvalid_d;
    logic        sb_a, sb_b, sb_c, sb_d, db_a, db_b, db_c, db_d;
    logic [7:0]  sbc_a, dbc_a, sbc_c, dbc_c, sbc_d, dbc_d;
    logic [1:0]  sbc_b, dbc_b;
    logic [8:0]  ea_a;
    logic [3:0]  ea_b, ea_c, ea_d;
    logic        eav_a, eav_b, eav_c, eav_d;

    // Model state: stored word and fault kind (0 none, 1 single, 2 double) per address.
    logic [31:0] mdata [16];
    int          minj  [16];
    int          mode_of [4] = '{2, 2, 1, 0};
    int          pipe_of [4] = '{1, 3, 2, 1};
    int          cmax    [4] = '{255, 3, 255, 255};
    int          msb [4];
    int          mdb [4];
    logic [8:0]  mea [4];
    bit          meav [4];
    logic [31:0] last_d [4];
    exp_t        q [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prot_mem_wrapper_2p #(.DATA_WIDTH(32), .DEPTH(512), .PROT_MODE(2), .RD_PIPE(1), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .wr(wr), .waddr(waddr9), .wdata(wdata), .inj_sb(inj_sb), .inj_db(inj_db),
        .rd(rd), .raddr(raddr9), .rdata(rdata_a), .rvalid(rvalid_a), .sb_err(sb_a), .db_err(db_a),
        .clr_err(clr_err), .sb_cnt(sbc_a), .db_cnt(dbc_a), .err_addr(ea_a), .err_addr_vld(eav_a));

    prot_mem_wrapper_2p #(.DATA_WIDTH(32), .DEPTH(16), .PROT_MODE(2), .RD_PIPE(3), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata), .inj_sb(inj_sb), .inj_db(inj_db),
        .rd(rd), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .sb_err(sb_b), .db_err(db_b),
        .clr_err(clr_err), .sb_cnt(sbc_b), .db_cnt(dbc_b), .err_addr(ea_b), .err_addr_vld(eav_b));

    prot_mem_wrapper_2p #(.DATA_WIDTH(32), .DEPTH(16), .PROT_MODE(1), .RD_PIPE(2), .CNT_WIDTH(8)) dut_c (
        .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata), .inj_sb(inj_sb), .inj_db(inj_db),
        .rd(rd), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c), .sb_err(sb_c), .db_err(db_c),
        .clr_err(clr_err), .sb_cnt(sbc_c), .db_cnt(dbc_c), .err_addr(ea_c), .err_addr_vld(eav_c));

    prot_mem_wrapper_2p #(.DATA_WIDTH(32), .DEPTH(16), .PROT_MODE(0), .RD_PIPE(1), .CNT_WIDTH(8)) dut_d (
        .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata), .inj_sb(inj_sb), .inj_db(inj_db),
        .rd(rd), .raddr(raddr), .rdata(rdata_d), .rvalid(rvalid_d), .sb_err(sb_d), .db_err(db_d),
        .clr_err(clr_err), .sb_cnt(sbc_d), .db_cnt(dbc_d), .err_addr(ea_d), .err_addr_vld(eav_d));

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=0x%08h required=0x%08h t=%0t", nm, id, act, req, $time);
        end
    endtask

    // Expected response of a read given the protection mode and the fault stored at the address.
    function automatic exp_t mk_exp(input int id, input logic [3:0] a);
        exp_t e;
        e.d = mdata[a];
        e.sb = 1'b0;
        e.db = 1'b0;
        e.addr = a;
        e.cyc = cyc + 1 + pipe_of[id];
        if (mode_of[id] == 1) begin
            if (minj[a] == 1) begin e.d = mdata[a] ^ 32'h1; e.db = 1'b1; end
            if (minj[a] == 2) e.d = mdata[a] ^ 32'h3;
        end else if (mode_of[id] == 2) begin
            if (minj[a] == 1) e.sb = 1'b1;
            if (minj[a] == 2) begin e.d = mdata[a] ^ 32'h3; e.db = 1'b1; end
        end
        return e;
    endfunction

    task automatic op(input bit w, input logic [3:0] wa, input logic [31:0] wd, input bit isb,
                      input bit idb, input bit r, input logic [3:0] ra, input bit clr);
        wr = w; waddr = wa; wdata = wd; inj_sb = isb; inj_db = idb;
        rd = r; raddr = ra; clr_err = clr;
        if (r) begin
            for (int id = 0; id < 4; id++) q[id].push_back(mk_exp(id, ra));
        end
        if (w) begin
            mdata[wa] = wd;
            minj[wa]  = idb ? 2 : (isb ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 4'd0, 32'd0, 0, 0, 0, 4'd0, 0);
    endtask

    task automatic check_dut(input int id, input logic rv, input logic [31:0] rdt, input logic sb,
                             input logic db, input logic [7:0] sc, input logic [7:0] dc,
                             input logic [8:0] ea_in, input logic eav_in);
        exp_t e;
        bit   fsb, fdb;
        logic [3:0] fa;
        if (rst) begin
            msb[id] = 0; mdb[id] = 0; meav[id] = 1'b0; mea[id] = '0; last_d[id] = '0;
            chk("rst_flags", id, {28'd0, rv, sb, db, eav_in}, 32'd0);
            chk("rst_counts", id, {16'd0, sc, dc}, 32'd0);
            chk("rst_err_addr", id, {23'd0, ea_in}, 32'd0);
            chk("rst_rdata", id, rdt, 32'd0);
            return;
        end
        chk("sb_cnt", id, {24'd0, sc}, msb[id]);
        chk("db_cnt", id, {24'd0, dc}, mdb[id]);
        chk("err_addr_vld", id, {31'd0, eav_in}, {31'd0, meav[id]});
        if (meav[id]) chk("err_addr", id, {23'd0, ea_in}, {23'd0, mea[id]});
        fsb = 1'b0; fdb = 1'b0; fa = '0;
        if (q[id].size() > 0 && q[id][0].cyc == cyc) begin
            e = q[id].pop_front();
            chk("rvalid", id, {31'd0, rv}, 32'd1);
            chk("rdata", id, rdt, e.d);
            chk("sb_err", id, {31'd0, sb}, {31'd0, e.sb});
            chk("db_err", id, {31'd0, db}, {31'd0, e.db});
            last_d[id] = e.d;
            fsb = e.sb; fdb = e.db; fa = e.addr;
        end else begin
            chk("rvalid_idle", id, {31'd0, rv}, 32'd0);
            chk("flags_idle", id, {30'd0, sb, db}, 32'd0);
            chk("rdata_hold", id, rdt, last_d[id]);
        end
        if (clr_err) begin
            msb[id] = fsb ? 1 : 0;
            mdb[id] = fdb ? 1 : 0;
            if (fsb || fdb) begin mea[id] = {5'd0, fa}; meav[id] = 1'b1; end
            else meav[id] = 1'b0;
        end else begin
            if (fsb && msb[id] < cmax[id]) msb[id]++;
            if (fdb && mdb[id] < cmax[id]) mdb[id]++;
            if (!meav[id] && (fsb || fdb)) begin mea[id] = {5'd0, fa}; meav[id] = 1'b1; end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, rvalid_a, rdata_a, sb_a, db_a, sbc_a, dbc_a, ea_a, eav_a);
        check_dut(1, rvalid_b, rdata_b, sb_b, db_b, {6'd0, sbc_b}, {6'd0, dbc_b}, {5'd0, ea_b}, eav_b);
        check_dut(2, rvalid_c, rdata_c, sb_c, db_c, sbc_c, dbc_c, {5'd0, ea_c}, eav_c);
        check_dut(3, rvalid_d, rdata_d, sb_d, db_d, sbc_d, dbc_d, {5'd0, ea_d}, eav_d);
    end

    initial begin
        int rr;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int a = 0; a < 16; a++) op(1, 4'(a), $urandom, 0, 0, 0, 4'd0, 0);

        op(1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 4'd0, 0);
        idle(1);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd5, 0);
        idle(4);

        op(1, 4'd7, 32'h1234_5678, 1, 0, 0, 4'd0, 0);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd7, 0);
        idle(4);
        op(1, 4'd9, 32'hCAFE_F00D, 0, 1, 0, 4'd0, 0);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd9, 0);
        idle(5);
        op(0, 4'd0, 32'd0, 0, 0, 0, 4'd0, 1);
        idle(2);

        op(1, 4'd3, 32'h2, 0, 0, 0, 4'd0, 0);
        op(1, 4'd3, 32'h1, 0, 0, 1, 4'd3, 0);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd3, 0);
        for (int a = 0; a < 4; a++) op(0, 4'd0, 32'd0, 0, 0, 1, 4'(a), 0);
        idle(4);

        op(1, 4'd11, 32'h0F0F_00FF, 1, 0, 0, 4'd0, 0);
        for (int i = 0; i < 5; i++) op(0, 4'd0, 32'd0, 0, 0, 1, 4'd11, 0);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            rr = $urandom_range(0, 7);
            op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, rr == 0, rr == 1,
               $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
        end
        idle(6);

        op(1, 4'd6, 32'h600D_DA7A, 0, 0, 0, 4'd0, 0);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd6, 0);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd6, 0);
        rst = 1'b1;
        wr = 1'b0; rd = 1'b0; inj_sb = 1'b0; inj_db = 1'b0; clr_err = 1'b0;
        for (int id = 0; id < 4; id++) q[id].delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd6, 0);
        op(0, 4'd0, 32'd0, 0, 0, 1, 4'd5, 0);
        idle(8);

        for (int id = 0; id < 4; id++) chk("queue_drained", id, q[id].size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
